// File: rtl/r200_fetchq_pkg.sv
// Shared constants for the r200 instruction fetch queue.
package r200_fetchq_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Occupancy-count width: must hold 0..depth inclusive.
  function automatic int cntw_f(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/r200_fetchq_fifo_ptr.sv
// Mod-DEPTH ring pointer with enable and clear; wraps explicitly so DEPTH need not be a power of two.
module r200_fifo_ptr #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/r200_fetchq.sv
// DEPTH-entry fetch queue between IF and ID, single-cycle flush on redirect, optional empty bypass.
module r200_fetchq
  import r200_fetchq_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0,
  parameter int CNTW   = cntw_f(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            enq_valid,
  output logic            enq_ready,
  input  logic [XLEN-1:0] enq_instrn,
  input  logic [XLEN-1:0] enq_pc,
  output logic            deq_valid,
  input  logic            deq_ready,
  output logic [XLEN-1:0] deq_instrn,
  output logic [XLEN-1:0] deq_pc,
  output logic [XLEN-1:0] deq_pcp4,
  output logic [CNTW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] mem_instrn [DEPTH];
  logic [XLEN-1:0] mem_pc     [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CNTW-1:0] count_q;
  logic            full;
  logic            empty;
  logic            bypass_act;
  logic            pass_through;
  logic            enq_fire;
  logic            deq_fire;
  logic            wr_en;
  logic            rd_en;

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);

  // rst and flush both block the handshake in the same cycle they are seen.
  assign enq_ready  = !full && !flush && !rst;
  assign bypass_act = (BYPASS != 0) && empty && enq_valid && !flush && !rst;
  assign deq_valid  = !rst && !flush && (!empty || bypass_act);

  assign deq_instrn = bypass_act ? enq_instrn : mem_instrn[rd_ptr];
  assign deq_pc     = bypass_act ? enq_pc     : mem_pc[rd_ptr];
  assign deq_pcp4   = deq_pc + XLEN'(4);
  assign count      = rst ? '0 : count_q;

  assign enq_fire     = enq_valid && enq_ready;
  assign deq_fire     = deq_valid && deq_ready;
  // A bypassed item consumed the same cycle never touches storage.
  assign pass_through = bypass_act && deq_ready;
  assign wr_en        = enq_fire && !pass_through;
  assign rd_en        = deq_fire && !pass_through;

  r200_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (rd_en),
    .ptr (rd_ptr)
  );

  r200_fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (wr_en),
    .ptr (wr_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_instrn[wr_ptr] <= enq_instrn;
      mem_pc[wr_ptr]     <= enq_pc;
    end
  end

endmodule

// File: tb/tb_r200_fetchq.sv
// Directed bench for r200_fetchq: DEPTH=4 table, DEPTH=3 wrap sequence, BYPASS=1 sequence.
module tb_r200_fetchq;

  logic        clk = 1'b0;
  logic        rst, flush, enq_valid, deq_ready;
  logic [31:0] enq_instrn, enq_pc;

  logic        er4, dv4, er3, dv3, erb, dvb;
  logic [31:0] di4, dp4, dq4, di3, dp3, dq3, dib, dpb, dqb;
  logic [2:0]  c4, cb;
  logic [1:0]  c3;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] IMASK = 32'hA5A5_0013;

  always #5 clk = ~clk;

  r200_fetchq #(.XLEN(32), .DEPTH(4), .BYPASS(0)) u_d4 (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(er4),
    .enq_instrn(enq_instrn), .enq_pc(enq_pc), .deq_valid(dv4), .deq_ready(deq_ready),
    .deq_instrn(di4), .deq_pc(dp4), .deq_pcp4(dq4), .count(c4));

  r200_fetchq #(.XLEN(32), .DEPTH(3), .BYPASS(0)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(er3),
    .enq_instrn(enq_instrn), .enq_pc(enq_pc), .deq_valid(dv3), .deq_ready(deq_ready),
    .deq_instrn(di3), .deq_pc(dp3), .deq_pcp4(dq3), .count(c3));

  r200_fetchq #(.XLEN(32), .DEPTH(4), .BYPASS(1)) u_bp (
    .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid), .enq_ready(erb),
    .enq_instrn(enq_instrn), .enq_pc(enq_pc), .deq_valid(dvb), .deq_ready(deq_ready),
    .deq_instrn(dib), .deq_pc(dpb), .deq_pcp4(dqb), .count(cb));

  typedef struct {
    logic        rst;
    logic        flush;
    logic        ev;
    logic [31:0] pc;
    logic        dr;
    logic        x_er;
    logic        x_dv;
    logic [31:0] x_pc;
    int          x_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive at the falling edge, sample 1 time unit later, well away from the rising edge.
  task automatic drive(input logic r, input logic f, input logic ev, input logic [31:0] instr,
                       input logic [31:0] pc, input logic dr);
    @(negedge clk);
    rst = r; flush = f; enq_valid = ev; enq_instrn = instr; enq_pc = pc; deq_ready = dr;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
    enq_instrn = '0; enq_pc = '0;

    // rst flush ev pc dr | er dv pc cnt
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h4,        1'b0, 1'b1, 1'b1, 32'h0,        1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h8,        1'b0, 1'b1, 1'b1, 32'h0,        2});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'hC,        1'b0, 1'b1, 1'b1, 32'h0,        3});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        4});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h10,       1'b0, 1'b0, 1'b1, 32'h0,        4});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        4});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h4,        3});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h8,        2});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC,        1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0,        0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h20,       1'b0, 1'b1, 1'b0, 32'h0,        0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h24,       1'b0, 1'b1, 1'b1, 32'h20,       1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h28,       1'b0, 1'b1, 1'b1, 32'h20,       2});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 32'h2C,       1'b1, 1'b0, 1'b0, 32'h0,        3});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 1'b1, 1'b0, 32'h0,        0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h40,       1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 32'h40,       1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h40,       2});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 32'h50,       1'b0, 1'b1, 1'b1, 32'hFFFFFFFC, 1});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 32'h54,       1'b1, 1'b0, 1'b0, 32'h0,        0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 32'h60,       1'b1, 1'b0, 1'b0, 32'h0,        0});

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].ev, tbl[i].pc ^ IMASK, tbl[i].pc, tbl[i].dr);
      chk($sformatf("v%0d enq_ready", i), {31'b0, er4}, {31'b0, tbl[i].x_er});
      chk($sformatf("v%0d deq_valid", i), {31'b0, dv4}, {31'b0, tbl[i].x_dv});
      chk($sformatf("v%0d count", i), {29'b0, c4}, tbl[i].x_cnt);
      if (tbl[i].x_dv) begin
        chk($sformatf("v%0d deq_pc", i), dp4, tbl[i].x_pc);
        chk($sformatf("v%0d deq_pcp4", i), dq4, tbl[i].x_pc + 32'd4);
        chk($sformatf("v%0d deq_instrn", i), di4, tbl[i].x_pc ^ IMASK);
      end
    end

    // PC wrap spot check with a hand value: load FFFFFFFC alone and look at pcp4.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h13, 32'hFFFFFFFC, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("wrap pcp4", dq4, 32'h0000_0000);

    // DEPTH=3 wrap-around: one entry in flight, then 6 enq/deq pairs.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'h100, 32'h1000, 1'b0);
    for (int i = 1; i < 7; i++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h100 + i, 32'h1000 + 4 * i, 1'b1);
      chk($sformatf("d3 instrn %0d", i - 1), di3, 32'h100 + i - 1);
      chk($sformatf("d3 count %0d", i - 1), {30'b0, c3}, 32'd1);
      chk($sformatf("d3 valid %0d", i - 1), {31'b0, dv3}, 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("d3 instrn 6", di3, 32'h106);
    chk("d3 pc 6", dp3, 32'h1018);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("d3 drained count", {30'b0, c3}, 32'd0);
    chk("d3 drained valid", {31'b0, dv3}, 32'd0);

    // Bypass: pass-through when consumed, stored when ID stalls.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 32'hB0, 32'h80, 1'b1);
    chk("bp same-cycle valid", {31'b0, dvb}, 32'd1);
    chk("bp same-cycle pc", dpb, 32'h80);
    chk("bp same-cycle instrn", dib, 32'hB0);
    chk("bp pcp4", dqb, 32'h84);
    chk("nobp same-cycle valid", {31'b0, dv4}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("bp pass count", {29'b0, cb}, 32'd0);
    chk("bp pass valid", {31'b0, dvb}, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 32'hB4, 32'h84, 1'b0);
    chk("bp stall valid", {31'b0, dvb}, 32'd1);
    chk("bp stall count", {29'b0, cb}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("bp stored count", {29'b0, cb}, 32'd1);
    chk("bp stored pc", dpb, 32'h84);
    chk("bp stored instrn", dib, 32'hB4);
    // Flush on an empty bypass queue must not forward the wrong-path item.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 32'hB8, 32'h88, 1'b1);
    chk("bp flush valid", {31'b0, dvb}, 32'd0);
    chk("bp flush ready", {31'b0, erb}, 32'd0);

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/r200_fetchq.md
Name: r200_fetchq

Overview:
- Parametrised instruction fetch queue between the IF stage and the IF/ID pipeline register of the r200 core.
- Decouples IF from ID stalls: IF keeps fetching while ID is held.
- On a branch or jump redirect, all queued wrong-path instructions are discarded in one cycle.
- Replaces the single-entry if_id_reg retire path with a DEPTH-entry ring buffer, plus an optional empty-queue bypass.

Parameters:
- XLEN, 32, width of the instruction word and the PC.
- DEPTH, 4, number of queue entries; legal values are 2 and up, not limited to powers of two.
- BYPASS, 0, when 1 an enqueue into an empty queue is presented on deq_* in the same cycle.
- CNTW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  redirect from pccont; drops all entries.
- enq_valid  in  1  IF presents an instruction.
- enq_ready  out  1  queue accepts the instruction this cycle.
- enq_instrn  in  XLEN  fetched instruction.
- enq_pc  in  XLEN  PC of the fetched instruction.
- deq_valid  out  1  head entry is valid.
- deq_ready  in  1  ID consumes the head (it is not stalled).
- deq_instrn  out  XLEN  head instruction.
- deq_pc  out  XLEN  head PC.
- deq_pcp4  out  XLEN  head PC + 4.
- count  out  CNTW  current occupancy.

Behaviour:
- Handshake rules:
  - An enqueue fires when enq_valid & enq_ready; a dequeue fires when deq_valid & deq_ready.
  - enq_ready = !full & !flush. It is independent of deq_ready, so a full queue does not accept on the same cycle it dequeues.
- Storage and pointers:
  - Ring buffer with rd_ptr and wr_ptr of width $clog2(DEPTH).
  - Each pointer wraps explicitly from DEPTH-1 to 0.
  - count tracks occupancy; full = (count == DEPTH), empty = (count == 0).
- Outputs:
  - Non-bypass: deq_valid = !empty, and deq_* come from mem[rd_ptr]. Latency from enqueue to deq_valid is 1 cycle.
  - deq_pcp4 = deq_pc + 4, modulo 2^XLEN, so PC 32'hFFFFFFFC gives 32'h00000000.
- Bypass (BYPASS=1):
  - When empty & enq_valid & !flush: deq_valid = 1 and deq_* = enq_*, combinationally.
  - If deq_ready is also high, the item passes through: no write, pointers unchanged, count stays 0.
  - If deq_ready is low, the item is written normally.
- Simultaneous enqueue and dequeue (not full): both pointers advance and count is unchanged.
- Flush:
  - Takes priority over everything.
  - Next cycle: rd_ptr = wr_ptr = 0 and count = 0.
  - Same cycle: deq_valid = 0 and enq_ready = 0, so nothing on the wrong path is accepted or delivered.
- Reset (synchronous, also mid-operation):
  - rst high at a rising edge sets pointers and count to 0.
  - Outputs while rst is high: deq_valid = 0, enq_ready = 0, count = 0.
  - Data array contents are not reset. deq_instrn / deq_pc read unspecified data while deq_valid = 0; the bench must not check them then.
- rst and flush together behave as rst.
- An enqueue attempted while full is ignored, with no state change. IF must hold enq_* until enq_ready.
- A dequeue attempted while empty (non-bypass) is ignored.
- Invariants: count never exceeds DEPTH or underflows; order is strictly FIFO.

Decomposition:
- r200_pkg (or cpu.vh):
  - XLEN default.
  - INSTR_NOP = 32'h00000013, used by ID when deq_valid = 0.
  - Localparam CNTW formula.
- One sub-module, r200_fifo_ptr: a parametrised mod-DEPTH pointer incrementer with enable and clear, instantiated for rd_ptr and wr_ptr.
- Storage and the count logic stay in the top module.

Test Plan:
- Reset then fill (DEPTH=4): rst 2 cycles, then enqueue PCs 0x0/0x4/0x8/0xC with deq_ready=0.
  - count=1..4; enq_ready=0 after the 4th.
  - deq_pc=0x0, deq_pcp4=0x4.
- Drain in order: with the queue full, deq_ready=1 for 4 cycles.
  - deq_pc = 0x0, 0x4, 0x8, 0xC.
  - count=0 and deq_valid=0 on cycle 5.
- Wrap-around (DEPTH=3): 7 interleaved enq/deq pairs with instrn 0x100+i.
  - Outputs appear in order 0x100..0x106.
  - count holds at 1 throughout the steady state.
- Flush mid-stream: 3 entries queued, flush=1 with enq_valid=1.
  - Same cycle: enq_ready=0, deq_valid=0.
  - Next cycle: count=0, and a new enqueue of PC 0x40 appears at the head.
- Bypass (BYPASS=1): empty queue, enq PC 0x80 with deq_ready=1.
  - deq_valid=1 and deq_pc=0x80 the same cycle; count stays 0.
  - Repeat with deq_ready=0: count=1 next cycle.
- PC wrap and reset mid-operation:
  - Enq PC 0xFFFFFFFC gives deq_pcp4=0x00000000.
  - Assert rst with 2 entries held: next cycle count=0 and deq_valid=0.
